// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_pkg: shared types and constants for the pipeline issue/stall controller.
//   state_t         issue FSM states (RUN, DRAIN, HALTED)
//   ASIZE / NREG    register-file address width and register count
//   BUBBLE_*        control encoding loaded into ID/EXE for a bubble
package pipe_pkg;

    localparam int ASIZE = 5;
    localparam int NREG  = 2 ** ASIZE;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    localparam logic [3:0] BUBBLE_ALUOP  = 4'd0;
    localparam logic       BUBBLE_ALUSRC = 1'b0;

endpackage

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// reg_scoreboard: per-register busy bits for outstanding writes.
//   clk, rst            clock, async active-high reset
//   set_en / set_addr   mark a register busy (issued write)
//   clr_en / clr_addr   clear a register (WB retire); set wins on collision
//   raddr1/raddr2/waddr lookup ports -> busy1/busy2/busyw
//   busy_vec            full scoreboard
module reg_scoreboard #(
    parameter int ASIZE   = pipe_pkg::ASIZE,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [ASIZE-1:0]      set_addr,
    input  logic                  clr_en,
    input  logic [ASIZE-1:0]      clr_addr,
    input  logic [ASIZE-1:0]      raddr1,
    input  logic [ASIZE-1:0]      raddr2,
    input  logic [ASIZE-1:0]      waddr,
    output logic                  busy1,
    output logic                  busy2,
    output logic                  busyw,
    output logic [2**ASIZE-1:0]   busy_vec
);

    localparam int NREG = 2 ** ASIZE;

    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;

    always_comb begin
        set_mask = (set_en && !(R0_ZERO && set_addr == '0)) ? (NREG'(1) << set_addr) : '0;
        clr_mask = clr_en ? (NREG'(1) << clr_addr) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy_vec <= '0;
        else
            busy_vec <= (busy_vec & ~clr_mask) | set_mask;
    end

    // Register 0 is hard-wired, so it never reports busy even if queried.
    assign busy1 = busy_vec[raddr1] & ~(R0_ZERO && raddr1 == '0);
    assign busy2 = busy_vec[raddr2] & ~(R0_ZERO && raddr2 == '0);
    assign busyw = busy_vec[waddr]  & ~(R0_ZERO && waddr  == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: issue/stall controller beside the ID/EXE register.
//   id_*            ID-stage instruction (valid, sources, dest, write enable)
//   wb_valid/waddr  register write retiring in WB
//   halt_req        level request to drain and halt issue; halt_ack when done
//   issue           ID instruction moves into ID/EXE
//   pc_hold/ifid_hold  freeze front end on a stall
//   idexe_bubble    ID/EXE loads zero controls
//   busy_vec        scoreboard, stall_cnt saturating stall count, wd_err sticky
module pipe_hazard_ctrl #(
    parameter int ASIZE    = pipe_pkg::ASIZE,
    parameter bit R0_ZERO  = 1'b1,
    parameter int CNT_W    = 16,
    parameter int WD_LIMIT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [ASIZE-1:0]     id_raddr1,
    input  logic [ASIZE-1:0]     id_raddr2,
    input  logic                 id_uses_r2,
    input  logic [ASIZE-1:0]     id_waddr,
    input  logic                 id_wen,
    input  logic                 wb_valid,
    input  logic [ASIZE-1:0]     wb_waddr,
    input  logic                 halt_req,
    output logic                 issue,
    output logic                 pc_hold,
    output logic                 ifid_hold,
    output logic                 idexe_bubble,
    output logic                 halt_ack,
    output logic [2**ASIZE-1:0]  busy_vec,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic                 wd_err
);

    import pipe_pkg::*;

    localparam int             RW     = $clog2(WD_LIMIT + 1);
    localparam logic [RW-1:0]  WD_MAX = RW'(WD_LIMIT);

    state_t          state, state_nxt;
    logic            busy1, busy2, busyw, hazard, stall;
    logic [RW-1:0]   run_cnt, run_nxt;

    reg_scoreboard #(.ASIZE(ASIZE), .R0_ZERO(R0_ZERO)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (issue & id_wen),
        .set_addr (id_waddr),
        .clr_en   (wb_valid),
        .clr_addr (wb_waddr),
        .raddr1   (id_raddr1),
        .raddr2   (id_raddr2),
        .waddr    (id_waddr),
        .busy1    (busy1),
        .busy2    (busy2),
        .busyw    (busyw),
        .busy_vec (busy_vec)
    );

    // No WB bypass: a source cleared this cycle still stalls one more cycle.
    assign hazard       = id_valid & (busy1 | (id_uses_r2 & busy2) | (id_wen & busyw));
    assign issue        = (state == RUN) & id_valid & ~hazard;
    assign stall        = id_valid & ~issue;
    assign pc_hold      = stall;
    assign ifid_hold    = stall;
    assign idexe_bubble = ~issue;
    assign halt_ack     = (state == HALTED);

    always_comb begin
        state_nxt = state;
        state_nxt = (state == RUN)                      ? (halt_req ? DRAIN : RUN) :
                    !halt_req                           ? RUN :
                    (state == DRAIN && busy_vec == '0)  ? HALTED : state;
    end

    // Run length counts only RUN-state hazard stalls; drain stalls are expected.
    always_comb begin
        run_nxt = run_cnt;
        run_nxt = (!id_valid || issue)                            ? '0 :
                  (state == RUN && hazard && run_cnt != WD_MAX)   ? run_cnt + RW'(1) : run_cnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            stall_cnt <= '0;
            run_cnt   <= '0;
            wd_err    <= 1'b0;
        end else begin
            state     <= state_nxt;
            stall_cnt <= (stall && stall_cnt != '1) ? stall_cnt + CNT_W'(1) : stall_cnt;
            run_cnt   <= run_nxt;
            wd_err    <= wd_err | (run_nxt == WD_MAX);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed bench with an expected-result queue for the
// per-cycle issue/hold/bubble outputs and direct checks of registered state.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_uses_r2, id_wen, wb_valid, halt_req;
    logic [4:0]  id_raddr1, id_raddr2, id_waddr, wb_waddr;
    logic        issue, pc_hold, ifid_hold, idexe_bubble, halt_ack, wd_err;
    logic [31:0] busy_vec;
    logic [15:0] stall_cnt;

    typedef struct {
        logic iss;
        logic hold;
        logic bub;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Environment pipeline: EXE and WB destination slots fed by expected issues.
    logic       exe_v = 1'b0, wb_v = 1'b0, wb_off = 1'b0;
    logic [4:0] exe_a = '0, wb_a = '0;

    pipe_hazard_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_raddr1    (id_raddr1),
        .id_raddr2    (id_raddr2),
        .id_uses_r2   (id_uses_r2),
        .id_waddr     (id_waddr),
        .id_wen       (id_wen),
        .wb_valid     (wb_valid),
        .wb_waddr     (wb_waddr),
        .halt_req     (halt_req),
        .issue        (issue),
        .pc_hold      (pc_hold),
        .ifid_hold    (ifid_hold),
        .idexe_bubble (idexe_bubble),
        .halt_ack     (halt_ack),
        .busy_vec     (busy_vec),
        .stall_cnt    (stall_cnt),
        .wd_err       (wd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic [4:0] a1, input logic [4:0] a2, input logic u,
                        input logic [4:0] wa, input logic we, input logic hr, input logic ex);
        exp_t e;
        id_valid   = v;
        id_raddr1  = a1;
        id_raddr2  = a2;
        id_uses_r2 = u;
        id_waddr   = wa;
        id_wen     = we;
        halt_req   = hr;
        wb_valid   = wb_v & ~wb_off;
        wb_waddr   = wb_a;
        q.push_back('{iss: ex, hold: v & ~ex, bub: ~ex});
        @(negedge clk);
        e = q.pop_front();
        chk("issue", {31'd0, issue}, {31'd0, e.iss});
        chk("pc_hold", {31'd0, pc_hold}, {31'd0, e.hold});
        chk("ifid_hold", {31'd0, ifid_hold}, {31'd0, e.hold});
        chk("idexe_bubble", {31'd0, idexe_bubble}, {31'd0, e.bub});
        @(posedge clk);
        #1;
        wb_v  = exe_v;
        wb_a  = exe_a;
        exe_v = ex & we;
        exe_a = wa;
    endtask

    task automatic idle(input logic hr);
        step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, hr, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        {id_valid, id_uses_r2, id_wen, wb_valid, halt_req} = '0;
        {id_raddr1, id_raddr2, id_waddr, wb_waddr} = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy_vec", busy_vec, 32'd0);
        chk("rst stall_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("rst wd_err", {31'd0, wd_err}, 32'd0);
        chk("rst halt_ack", {31'd0, halt_ack}, 32'd0);
        chk("rst issue", {31'd0, issue}, 32'd0);
        rst = 1'b0;

        // Independent back-to-back ops.
        step(1, 2, 3, 1, 1, 1, 0, 1);
        step(1, 5, 6, 1, 4, 1, 0, 1);
        chk("indep busy", busy_vec, 32'h12);
        chk("indep stall_cnt", {16'd0, stall_cnt}, 32'd0);
        idle(0);
        chk("indep busy drain1", busy_vec, 32'h10);
        idle(0);
        chk("indep busy drain2", busy_vec, 32'd0);

        // RAW on r1: two stall cycles, issue on the third.
        step(1, 2, 3, 1, 1, 1, 0, 1);
        step(1, 1, 4, 1, 7, 1, 0, 0);
        step(1, 1, 4, 1, 7, 1, 0, 0);
        step(1, 1, 4, 1, 7, 1, 0, 1);
        chk("raw stall_cnt", {16'd0, stall_cnt}, 32'd2);
        idle(0);
        idle(0);
        chk("raw busy clear", busy_vec, 32'd0);

        // I-type ignores raddr2; R-type with the same raddr2 stalls.
        step(1, 2, 9, 1, 9, 1, 0, 1);
        step(1, 2, 9, 0, 10, 1, 0, 1);
        step(1, 2, 9, 1, 11, 1, 0, 0);
        step(1, 2, 9, 1, 11, 1, 0, 1);
        chk("itype stall_cnt", {16'd0, stall_cnt}, 32'd3);
        idle(0);
        idle(0);
        chk("itype busy clear", busy_vec, 32'd0);

        // Register 0 never becomes busy.
        step(1, 2, 3, 1, 0, 1, 0, 1);
        chk("r0 busy", busy_vec, 32'd0);
        step(1, 0, 0, 1, 5, 1, 0, 1);
        chk("r0 then r5 busy", busy_vec, 32'h20);
        idle(0);
        idle(0);

        // WAW on r12 stalls until the earlier write retires.
        step(1, 2, 3, 1, 12, 1, 0, 1);
        step(1, 4, 5, 1, 12, 1, 0, 0);
        step(1, 4, 5, 1, 12, 1, 0, 0);
        step(1, 4, 5, 1, 12, 1, 0, 1);
        chk("waw stall_cnt", {16'd0, stall_cnt}, 32'd5);
        chk("waw busy", busy_vec, 32'h1000);
        idle(0);
        idle(0);

        // Halt with two writes in flight: DRAIN 2 cycles, ack on the third.
        step(1, 2, 3, 1, 1, 1, 0, 1);
        step(1, 4, 5, 1, 6, 1, 0, 1);
        chk("halt busy", busy_vec, 32'h42);
        idle(1);
        chk("drain1 ack", {31'd0, halt_ack}, 32'd0);
        step(1, 2, 3, 1, 8, 1, 1, 0);
        chk("drain2 ack", {31'd0, halt_ack}, 32'd0);
        chk("drain2 busy", busy_vec, 32'd0);
        step(1, 2, 3, 1, 8, 1, 1, 0);
        chk("halted ack", {31'd0, halt_ack}, 32'd1);
        step(1, 2, 3, 1, 8, 1, 0, 0);
        chk("resume ack", {31'd0, halt_ack}, 32'd0);
        step(1, 2, 3, 1, 8, 1, 0, 1);
        chk("resume stall_cnt", {16'd0, stall_cnt}, 32'd8);
        chk("resume busy", busy_vec, 32'h100);
        idle(0);
        idle(0);

        // Watchdog: r3 never retires.
        step(1, 2, 4, 1, 3, 1, 0, 1);
        wb_off = 1'b1;
        for (int i = 1; i <= 67; i++) begin
            step(1, 3, 4, 1, 13, 1, 0, 0);
            chk($sformatf("wd_err after %0d", i), {31'd0, wd_err}, {31'd0, i >= 64});
        end
        chk("wd stall_cnt", {16'd0, stall_cnt}, 32'd75);
        chk("wd busy", busy_vec, 32'h8);

        // Asynchronous reset mid-stall.
        rst = 1'b1;
        #1;
        chk("async rst busy_vec", busy_vec, 32'd0);
        chk("async rst stall_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("async rst wd_err", {31'd0, wd_err}, 32'd0);
        chk("async rst halt_ack", {31'd0, halt_ack}, 32'd0);
        chk("async rst issue", {31'd0, issue}, 32'd1);
        chk("async rst pc_hold", {31'd0, pc_hold}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
